// File: rtl/led_p2s_sync_drv.sv
// led_p2s_sync_drv: parallel-to-serial driver for shift-register LED chains.
// Captures a word, clears the chain, shifts it out on LED_CLK, re-enables.
//
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   data        WIDTH-bit word, sampled only at frame capture
//   start       frame request, sampled in IDLE when AUTO=0
//   busy        high from the cycle after capture through LATCH
//   done        one-cycle pulse in the LATCH cycle
//   LED_CLK     serial clock, chain samples on its rising edge
//   LED_CLR     active-low chain clear
//   LED_DO      serial data
//   LED_EN      active-high output enable
module led_p2s_sync_drv #(
    parameter int WIDTH       = 16,
    parameter int HALF_PERIOD = 4,
    parameter int CLR_CYCLES  = 2,
    parameter int MSB_FIRST   = 1,
    parameter int AUTO        = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             LED_CLK,
    output logic             LED_CLR,
    output logic             LED_DO,
    output logic             LED_EN
);

    localparam int DW = $clog2(HALF_PERIOD + 1);
    localparam int BW = $clog2(WIDTH + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(HALF_PERIOD - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [3:0]    CLR_LAST = 4'(CLR_CYCLES - 1);

    localparam bit MSB_ON  = (MSB_FIRST != 0);
    localparam bit AUTO_ON = (AUTO != 0);
    localparam bit NO_CLR  = (CLR_CYCLES == 0);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SHIFT,
        LATCH
    } state_t;

    state_t           state, state_n;
    logic [DW-1:0]    div_cnt, div_n;
    logic [BW-1:0]    bit_cnt, bit_n;
    logic [3:0]       clr_cnt, clr_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic             phase, ph_n;
    logic             frame_valid, fv_n;
    logic             load;

    logic busy_d, done_d, clk_d, clrb_d, do_d, en_d;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            clr_cnt     <= '0;
            sreg        <= '0;
            phase       <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            state       <= state_n;
            div_cnt     <= div_n;
            bit_cnt     <= bit_n;
            clr_cnt     <= clr_n;
            sreg        <= sreg_n;
            phase       <= ph_n;
            frame_valid <= fv_n;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_n = state;
        div_n   = div_cnt;
        bit_n   = bit_cnt;
        clr_n   = clr_cnt;
        sreg_n  = sreg;
        ph_n    = phase;
        fv_n    = frame_valid;
        load    = 1'b0;
        unique case (state)
            IDLE: begin
                load = AUTO_ON || start;
            end
            CLEAR: begin
                if (clr_cnt == CLR_LAST) begin
                    state_n = SHIFT;
                end else begin
                    clr_n = clr_cnt + 4'd1;
                end
            end
            SHIFT: begin
                if (div_cnt == DIV_LAST) begin
                    div_n = '0;
                    if (!phase) begin
                        ph_n = 1'b1;
                    end else begin
                        // End of the high half: advance to the next bit
                        ph_n   = 1'b0;
                        sreg_n = MSB_ON ? (sreg << 1) : (sreg >> 1);
                        bit_n  = bit_cnt + BW'(1);
                        if (bit_cnt == BIT_LAST) begin
                            state_n = LATCH;
                        end
                    end
                end else begin
                    div_n = div_cnt + DW'(1);
                end
            end
            LATCH: begin
                load    = AUTO_ON;
                state_n = IDLE;
            end
        endcase
        if (load) begin
            sreg_n  = data;
            clr_n   = '0;
            state_n = NO_CLR ? SHIFT : CLEAR;
        end
        if (state_n == SHIFT && state != SHIFT) begin
            div_n = '0;
            bit_n = '0;
            ph_n  = 1'b0;
        end
        if (state_n == LATCH) begin
            fv_n = 1'b1;
        end
    end

    // Output decode from the next state so the pins come straight off flops
    always_comb begin
        busy_d = (state_n != IDLE);
        done_d = (state_n == LATCH);
        clk_d  = (state_n == SHIFT) && ph_n;
        clrb_d = (state_n != CLEAR);
        do_d   = (state_n == SHIFT) &&
                 (MSB_ON ? sreg_n[WIDTH-1] : sreg_n[0]);
        en_d   = (state_n == IDLE) ? fv_n : (state_n == LATCH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            LED_CLK <= 1'b0;
            LED_CLR <= 1'b1;
            LED_DO  <= 1'b0;
            LED_EN  <= 1'b0;
        end else begin
            busy    <= busy_d;
            done    <= done_d;
            LED_CLK <= clk_d;
            LED_CLR <= clrb_d;
            LED_DO  <= do_d;
            LED_EN  <= en_d;
        end
    end

endmodule

// File: tb/tb_led_p2s_sync_drv.sv
// tb_led_p2s_sync_drv: directed bench for led_p2s_sync_drv.
// Four instances cover MSB/LSB first, auto refresh and WIDTH=1.
module tb_led_p2s_sync_drv;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Instances A (MSB first) and B (LSB first) share stimulus
    logic [15:0] data_ab = 16'h0000;
    logic        start_ab = 1'b0;
    logic a_busy, a_done, a_clk, a_clr, a_do, a_en;
    logic b_busy, b_done, b_clk, b_clr, b_do, b_en;

    logic [7:0] data_c = 8'h3C;
    logic       start_c = 1'b0;
    logic c_busy, c_done, c_clk, c_clr, c_do, c_en;

    logic [0:0] data_d = 1'b0;
    logic       start_d = 1'b0;
    logic d_busy, d_done, d_clk, d_clr, d_do, d_en;

    led_p2s_sync_drv #(
        .WIDTH(16), .HALF_PERIOD(2), .CLR_CYCLES(2),
        .MSB_FIRST(1), .AUTO(0)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .data(data_ab), .start(start_ab),
        .busy(a_busy), .done(a_done), .LED_CLK(a_clk),
        .LED_CLR(a_clr), .LED_DO(a_do), .LED_EN(a_en)
    );

    led_p2s_sync_drv #(
        .WIDTH(16), .HALF_PERIOD(2), .CLR_CYCLES(2),
        .MSB_FIRST(0), .AUTO(0)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .data(data_ab), .start(start_ab),
        .busy(b_busy), .done(b_done), .LED_CLK(b_clk),
        .LED_CLR(b_clr), .LED_DO(b_do), .LED_EN(b_en)
    );

    led_p2s_sync_drv #(
        .WIDTH(8), .HALF_PERIOD(1), .CLR_CYCLES(0),
        .MSB_FIRST(1), .AUTO(1)
    ) u_c (
        .clk(clk), .rst_n(rst_n), .data(data_c), .start(start_c),
        .busy(c_busy), .done(c_done), .LED_CLK(c_clk),
        .LED_CLR(c_clr), .LED_DO(c_do), .LED_EN(c_en)
    );

    led_p2s_sync_drv #(
        .WIDTH(1), .HALF_PERIOD(1), .CLR_CYCLES(0),
        .MSB_FIRST(1), .AUTO(0)
    ) u_d (
        .clk(clk), .rst_n(rst_n), .data(data_d), .start(start_d),
        .busy(d_busy), .done(d_done), .LED_CLK(d_clk),
        .LED_CLR(d_clr), .LED_DO(d_do), .LED_EN(d_en)
    );

    logic [199:0] a_clk_h, a_do_h, a_clr_h, a_done_h, a_busy_h, a_en_h;
    logic [199:0] b_clk_h, b_do_h;
    logic [199:0] d_clk_h, d_do_h, d_done_h, d_busy_h;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Request a frame on A/B: the next rising edge is E0
    task automatic go_ab(input logic [15:0] d);
        @(negedge clk);
        data_ab  = d;
        start_ab = 1'b1;
        @(posedge clk);
    endtask

    // Record cycles 0..ncyc-1 after E0, optionally re-pulsing start
    // and changing data at given cycles
    task automatic rec_ab(input int ncyc, input int rs_at,
                          input int chg_at);
        for (int n = 0; n < ncyc; n++) begin
            @(negedge clk);
            a_clk_h[n]  = a_clk;
            a_do_h[n]   = a_do;
            a_clr_h[n]  = a_clr;
            a_done_h[n] = a_done;
            a_busy_h[n] = a_busy;
            a_en_h[n]   = a_en;
            b_clk_h[n]  = b_clk;
            b_do_h[n]   = b_do;
            if (n == 0) start_ab = 1'b0;
            if (n == rs_at) start_ab = 1'b1;
            if (n == rs_at + 1) start_ab = 1'b0;
            if (n == chg_at) data_ab = 16'hFFFF;
        end
    endtask

    // Bits seen at LED_CLK rises, first-seen bit ends up as MSB
    task automatic stream(input logic [199:0] ck, input logic [199:0] dd,
                          input int ncyc, output logic [15:0] w,
                          output int nr);
        w  = '0;
        nr = 0;
        for (int n = 1; n < ncyc; n++) begin
            if (ck[n] && !ck[n-1]) begin
                w = {w[14:0], dd[n]};
                nr++;
            end
        end
    endtask

    initial begin
        logic [15:0] w;
        int nr;
        int ndone;
        int dn, last, nb;
        logic [7:0] fb;
        logic pc;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", a_busy, 1'b0);
        check("rst_done", a_done, 1'b0);
        check("rst_clk", a_clk, 1'b0);
        check("rst_clr", a_clr, 1'b1);
        check("rst_do", a_do, 1'b0);
        check("rst_en", a_en, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_start", a_busy, 1'b0);

        // Basic frame A5C3
        go_ab(16'hA5C3);
        rec_ab(70, -1, -1);
        check("f1_clr0", a_clr_h[0], 1'b0);
        check("f1_clr1", a_clr_h[1], 1'b0);
        check("f1_clr2", a_clr_h[2], 1'b1);
        check("f1_busy0", a_busy_h[0], 1'b1);
        check("f1_en_shift", a_en_h[40], 1'b0);
        check("f1_done65", a_done_h[65], 1'b0);
        check("f1_done66", a_done_h[66], 1'b1);
        check("f1_busy66", a_busy_h[66], 1'b1);
        check("f1_busy67", a_busy_h[67], 1'b0);
        check("f1_en66", a_en_h[66], 1'b1);
        check("f1_en67", a_en_h[67], 1'b1);
        check("f1_clk4", a_clk_h[4], 1'b1);
        check("f1_clk6", a_clk_h[6], 1'b0);
        stream(a_clk_h, a_do_h, 70, w, nr);
        check("f1_a_rises", nr, 16);
        check("f1_a_word", w, 16'hA5C3);
        stream(b_clk_h, b_do_h, 70, w, nr);
        check("f1_b_word", w, 16'hC3A5);

        // LSB first with 0001
        go_ab(16'h0001);
        rec_ab(70, -1, -1);
        stream(b_clk_h, b_do_h, 70, w, nr);
        check("f2_b_rises", nr, 16);
        check("f2_b_first", w[15], 1'b1);
        check("f2_b_word", w, 16'h8000);
        stream(a_clk_h, a_do_h, 70, w, nr);
        check("f2_a_word", w, 16'h0001);

        // start re-pulsed at 10, data changed at 20
        go_ab(16'hA5C3);
        rec_ab(80, 10, 20);
        stream(a_clk_h, a_do_h, 80, w, nr);
        check("f3_a_word", w, 16'hA5C3);
        ndone = 0;
        for (int n = 0; n < 80; n++) ndone += int'(a_done_h[n]);
        check("f3_ndone", ndone, 1);
        check("f3_busy79", a_busy_h[79], 1'b0);

        // Mid-frame asynchronous reset at cycle 30
        go_ab(16'hA5C3);
        rec_ab(30, -1, -1);
        check("f4_busy29", a_busy_h[29], 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("f4_rst_busy", a_busy, 1'b0);
        check("f4_rst_en", a_en, 1'b0);
        check("f4_rst_clk", a_clk, 1'b0);
        check("f4_rst_clr", a_clr, 1'b1);
        check("f4_rst_b_busy", b_busy, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("f4_fv_cleared", a_en, 1'b0);
        check("f4_no_start", a_busy, 1'b0);
        go_ab(16'hA5C3);
        rec_ab(70, -1, -1);
        stream(a_clk_h, a_do_h, 70, w, nr);
        check("f4_rises", nr, 16);
        check("f4_word", w, 16'hA5C3);
        check("f4_done66", a_done_h[66], 1'b1);

        // Auto refresh on instance C
        dn   = 0;
        last = -1;
        nb   = 0;
        fb   = '0;
        pc   = 1'b0;
        for (int n = 0; n < 150 && dn < 5; n++) begin
            @(negedge clk);
            if (c_clk && !pc) begin
                fb = {fb[6:0], c_do};
                nb++;
            end
            pc = c_clk;
            if (c_done) begin
                dn++;
                if (last >= 0) begin
                    check("auto_period", n - last, 17);
                    check("auto_nbits", nb, 8);
                    check("auto_word", fb, (dn >= 4) ? 8'hFF : 8'h3C);
                end
                last = n;
                nb   = 0;
                fb   = '0;
            end
            if (dn == 2 && n == last + 5) data_c = 8'hFF;
        end
        check("auto_dones", dn, 5);

        // Minimal width on instance D
        @(negedge clk);
        data_d  = 1'b1;
        start_d = 1'b1;
        @(posedge clk);
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (n == 0) start_d = 1'b0;
            d_clk_h[n]  = d_clk;
            d_do_h[n]   = d_do;
            d_done_h[n] = d_done;
            d_busy_h[n] = d_busy;
        end
        check("w1_clk0", d_clk_h[0], 1'b0);
        check("w1_clk1", d_clk_h[1], 1'b1);
        check("w1_do1", d_do_h[1], 1'b1);
        check("w1_done1", d_done_h[1], 1'b0);
        check("w1_done2", d_done_h[2], 1'b1);
        check("w1_busy3", d_busy_h[3], 1'b0);
        stream(d_clk_h, d_do_h, 6, w, nr);
        check("w1_rises", nr, 1);
        check("w1_bit", w[0], 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_p2s_sync_drv.md
# led_p2s_sync_drv

Parametrised parallel-to-serial driver for the board's shift-register LED/segment chains, replacing the fixed 16-bit synchronous LED driver. It captures a WIDTH-bit word on a start request or continuously in auto-refresh mode. It clears the external register, shifts the word out on a divided serial clock in either bit order, then re-enables the outputs. It sits between the number-generation logic and the LED_CLK/LED_CLR/LED_DO/LED_EN pins.

## Interface
- WIDTH, 16: bits per frame, 1..64.
- HALF_PERIOD, 4: clk cycles per LED_CLK half-period, ≥1.
- CLR_CYCLES, 2: clk cycles LED_CLR is held low before shifting, 0..15. 0 skips the clear phase.
- MSB_FIRST, 1: 1 shifts data[WIDTH-1] first; 0 shifts data[0] first.
- AUTO, 0: 1 restarts a new frame immediately after each latch and ignores start.
- clk  in  1  system clock. All logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- data  in  WIDTH  word to display. It is sampled only at frame capture.
- start  in  1  frame request. It is sampled only in IDLE when AUTO=0.
- busy  out  1  high from the cycle after capture through the LATCH cycle.
- done  out  1  one-cycle pulse in the LATCH cycle.
- LED_CLK  out  1  serial clock to the external register. Data is taken on its rising edge.
- LED_CLR  out  1  active-low clear to the external register.
- LED_DO  out  1  serial data.
- LED_EN  out  1  output enable, active high.

## Operation
- FSM states: IDLE, CLEAR, SHIFT, LATCH.
- IDLE:
  - LED_CLK=0, LED_CLR=1, LED_DO=0.
  - LED_EN=1 if at least one frame has latched since reset, else 0.
  - start=1 (AUTO=0) or any cycle (AUTO=1): capture data into the shift register.
  - Then go to CLEAR, or to SHIFT if CLR_CYCLES=0.
- CLEAR: LED_CLR=0, LED_EN=0, held for CLR_CYCLES cycles. Then go to SHIFT.
- SHIFT:
  - LED_EN=0.
  - Per bit: LED_DO holds the current bit for 2·HALF_PERIOD cycles.
  - LED_CLK is 0 for the first HALF_PERIOD cycles and 1 for the second HALF_PERIOD cycles.
  - The shift register advances when the bit's high half ends.
  - After WIDTH bits, go to LATCH.
- LATCH:
  - Lasts one cycle: LED_CLK=0, LED_DO=0, LED_EN=1, done=1, busy=1.
  - Sets the "frame valid" flag.
  - Next state: IDLE if AUTO=0. If AUTO=1, capture data this cycle and go to CLEAR (or SHIFT if CLR_CYCLES=0).
- Counters:
  - Divider counter is $clog2(HALF_PERIOD+1) bits.
  - Bit counter is $clog2(WIDTH+1) bits.
  - Both are cleared on entry to SHIFT and never wrap mid-frame.
- Boundary conditions:
  - start while busy is ignored, not queued.
  - data changes after capture do not affect the frame in flight.
  - start held high continuously with AUTO=0 gives back-to-back frames with one IDLE cycle between them.
  - WIDTH=1 is legal: one LED_CLK pulse.
- Reset:
  - rst_n=0 forces IDLE at once, asynchronously, from any state including mid-SHIFT.
  - Reset values: busy=0, done=0, LED_CLK=0, LED_CLR=1, LED_DO=0, LED_EN=0.
  - Reset also clears the shift register, both counters and the frame-valid flag.
  - Removing reset does not start a frame by itself.

## Timing
- Capture edge E0: the rising edge that samples start=1 in IDLE. Cycle n is the nth cycle after E0, counting from 0.
- Cycles 0..CLR_CYCLES-1: CLEAR, LED_CLR=0.
- Cycles CLR_CYCLES .. CLR_CYCLES+2·HALF_PERIOD·WIDTH-1: SHIFT.
- Cycle CLR_CYCLES+2·HALF_PERIOD·WIDTH: LATCH, done=1.
- busy=0 again in the following cycle.
- Frame length: CLR_CYCLES+2·HALF_PERIOD·WIDTH+1 cycles.
  - AUTO=1: frames repeat with exactly this period.
  - AUTO=0 with start held: period is this plus 1.
- Serial timing: LED_DO is stable HALF_PERIOD cycles before each LED_CLK rise and HALF_PERIOD cycles after it.
- All outputs are registered; none is glitch-prone.

## Test plan
- Basic frame, MSB first: WIDTH=16, HALF_PERIOD=2, CLR_CYCLES=2, AUTO=0, data=16'hA5C3, start pulse.
  - LED_CLR=0 for cycles 0-1.
  - 16 LED_CLK rises sample 1010_0101_1100_0011.
  - done=1 at cycle 66; busy=0 at cycle 67; LED_EN=1 from cycle 66.
- LSB first: MSB_FIRST=0, data=16'h0001, same settings. The bit sampled at the first LED_CLK rise is 1 and the remaining 15 are 0.
- Ignored inputs during a frame:
  - start re-pulsed at cycle 10 produces no second frame.
  - data changed to 16'hFFFF at cycle 20 leaves the serial stream as 16'hA5C3.
- Mid-frame reset: rst_n low at cycle 30 of a frame.
  - Outputs take reset values in the same cycle, asynchronously: LED_EN=0, LED_CLK=0.
  - After release, a new start produces a complete, correct frame.
- Auto refresh: AUTO=1, WIDTH=8, HALF_PERIOD=1, CLR_CYCLES=0, data=8'h3C.
  - done pulses every 17 cycles.
  - Each frame shifts 0011_1100.
  - Changing data to 8'hFF mid-frame takes effect in the next frame.
- Minimal width: WIDTH=1, HALF_PERIOD=1, CLR_CYCLES=0, data=1'b1. Exactly one LED_CLK pulse with LED_DO=1; done at cycle 2.
